// File: rtl/cic_interp_ctrl.sv
// cic_interp_ctrl: sample FIFO and stream sequencer feeding a 2x CIC interpolator.
// It buffers upstream samples and waits for a prime level before streaming.
// It pops one sample per clock while running and counts underruns.
// When streaming stops, it drains the FIFO and then flushes the interpolator with zeros.
module cic_interp_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PRIME_LVL  = 2,
  parameter int unsigned SETTLE     = 3
) (
  input  logic        clk_3p84MHz,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] cic_x,
  output logic        cic_run,
  output logic        underrun,
  output logic [7:0]  underrun_cnt,
  output logic [1:0]  state
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = 4;
  localparam int unsigned UW = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [CW-1:0] DEPTH_C      = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PRIME_C      = CW'(PRIME_LVL);
  localparam logic [SW-1:0] SETTLE_C     = SW'(SETTLE);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE - 1);
  localparam logic [UW-1:0] UCNT_MAX     = {UW{1'b1}};

  logic [1:0]    r_state;
  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_settle;
  logic [SW-1:0] r_flush;
  logic [DW-1:0] r_cic_x;
  logic          r_cic_run;
  logic          r_underrun;
  logic [UW-1:0] r_underrun_cnt;

  logic [1:0]    w_state_nxt;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_clear;
  logic [CW-1:0] w_count_plus;
  logic [SW-1:0] w_settle_nxt;
  logic [SW-1:0] w_flush_nxt;
  logic [DW-1:0] w_cic_x_nxt;
  logic          w_cic_run_nxt;
  logic          w_underrun_nxt;
  logic          w_ucnt_inc;

  // Upstream handshake: accept only while priming or running with room, never in reset.
  assign w_ready      = reset && ((r_state == ST_PRIME) || (r_state == ST_RUN)) && (r_count < DEPTH_C);
  assign w_push       = s_valid && w_ready;
  assign w_count_plus = r_count + CW'(w_push);

  assign s_ready      = w_ready;
  assign cic_x        = r_cic_x;
  assign cic_run      = r_cic_run;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_underrun_cnt;
  assign state        = r_state;

  // State register.
  always_ff @(posedge clk_3p84MHz) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, pop control and next values of the registered outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_clear        = 1'b0;
    w_settle_nxt   = r_settle;
    w_flush_nxt    = r_flush;
    w_cic_x_nxt    = '0;
    w_underrun_nxt = 1'b0;
    w_ucnt_inc     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_clear      = 1'b1;
        w_settle_nxt = '0;
        w_flush_nxt  = '0;
        if (enable) begin
          w_state_nxt = ST_PRIME;
        end
      end

      ST_PRIME: begin
        w_settle_nxt = '0;
        w_flush_nxt  = '0;
        if (!enable) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_count_plus >= PRIME_C) begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_cic_x_nxt = r_mem[r_rd_ptr];
        end else begin
          w_underrun_nxt = 1'b1;
          w_ucnt_inc     = 1'b1;
        end
        if (r_settle < SETTLE_C) begin
          w_settle_nxt = r_settle + SW'(1);
        end
        w_flush_nxt = '0;
        if (!enable) begin
          w_state_nxt = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Empty out queued samples first, then push SETTLE zeros through the interpolator.
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_cic_x_nxt = r_mem[r_rd_ptr];
        end else if (r_flush == SETTLE_LAST) begin
          w_flush_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_flush_nxt = r_flush + SW'(1);
        end
      end

      default: begin
        w_clear     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_cic_run_nxt = ((w_state_nxt == ST_RUN) && (w_settle_nxt == SETTLE_C)) ||
                    (w_state_nxt == ST_DRAIN);
  end

  // FIFO storage; pointers and count guard every read, so the array needs no reset.
  always_ff @(posedge clk_3p84MHz) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_3p84MHz) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Settle and flush counters.
  always_ff @(posedge clk_3p84MHz) begin
    if (!reset) begin
      r_settle <= '0;
      r_flush  <= '0;
    end else begin
      r_settle <= w_settle_nxt;
      r_flush  <= w_flush_nxt;
    end
  end

  // Registered interpolator-side outputs.
  always_ff @(posedge clk_3p84MHz) begin
    if (!reset) begin
      r_cic_x    <= '0;
      r_cic_run  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_cic_x    <= w_cic_x_nxt;
      r_cic_run  <= w_cic_run_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  // Saturating underrun counter, cleared only by reset.
  always_ff @(posedge clk_3p84MHz) begin
    if (!reset) begin
      r_underrun_cnt <= '0;
    end else if (w_ucnt_inc && (r_underrun_cnt != UCNT_MAX)) begin
      r_underrun_cnt <= r_underrun_cnt + UW'(1);
    end
  end

endmodule

// File: doc/cic_interp_ctrl.md
CIC_INTERP_CTRL -- requirements
Module: cic_interp_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: sample buffer depth in entries; a power of two, at least 2.
REQ-002 Parameter PRIME_LVL, default 2: FIFO fill level needed before streaming starts; 1 to FIFO_DEPTH.
REQ-003 Parameter SETTLE, default 3: interpolator pipeline latency in clk_3p84MHz cycles; 1 to 15.
REQ-004 The block SHALL provide these ports, clock and reset first:
- clk_3p84MHz  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low.
- enable  in  1  level request to stream.
- s_data  in  16  upstream sample, two's complement.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  block accepts s_data this cycle.
- cic_x  out  16  registered sample to the 2x interpolator input.
- cic_run  out  1  interpolator output is valid.
- underrun  out  1  one-cycle pulse when RUN finds the FIFO empty.
- underrun_cnt  out  8  saturating underrun count.
- state  out  2  IDLE=0, PRIME=1, RUN=2, DRAIN=3.

Function
REQ-005 A push SHALL occur only when s_valid=1 and s_ready=1.
- s_ready = (state is PRIME or RUN) and count < FIFO_DEPTH.
- s_ready is combinational from the registered state and count.
REQ-006 The FIFO SHALL be first-in first-out with wrapping pointers and count range 0 to FIFO_DEPTH.
- Push and pop in the same cycle: count unchanged.
- No bypass: a sample pushed in cycle n is poppable no earlier than n+1.
REQ-007 IDLE:
- cic_x = 0, cic_run = 0.
- FIFO pointers and count held at 0.
- enable = 1 -> PRIME on the next edge.
REQ-008 PRIME:
- cic_x = 0, no pops.
- enable = 0 -> IDLE; FIFO cleared on the same edge.
- Otherwise, count reaches PRIME_LVL (including that cycle's push) -> RUN.
REQ-009 RUN pops exactly one entry per cycle into cic_x, registered, giving one cycle of latency.
- If count = 0: cic_x <= 0, underrun = 1 for that cycle, underrun_cnt increments.
- underrun_cnt saturates at 255 and never wraps.
REQ-010 A settle counter SHALL clear on entry to RUN.
- It increments each RUN cycle up to SETTLE.
- cic_run = 1 while in RUN and counter = SETTLE.
- cic_run = 1 on DRAIN cycles until drain completes.
- cic_run = 0 in all other cases.
REQ-011 RUN with enable = 0 -> DRAIN; that cycle's pop still occurs.
REQ-012 DRAIN:
- s_ready = 0.
- Pops remaining entries one per cycle.
- Then drives cic_x = 0 for SETTLE further cycles to flush interpolator memory.
- Then -> IDLE.
- Empty FIFO in DRAIN is not an underrun.
REQ-013 enable is ignored during DRAIN; re-entry to PRIME happens only from IDLE.
REQ-014 underrun_cnt SHALL clear only on reset; it holds its value through IDLE.
REQ-015 cic_x SHALL carry s_data bit-exact; no scaling or sign change.

Reset
REQ-016 reset = 0 on any edge SHALL force, regardless of state or an operation in progress:
- state = IDLE.
- FIFO empty, all pointers 0.
- cic_x = 0, cic_run = 0, underrun = 0.
- underrun_cnt = 0, settle counter = 0.
REQ-017 During reset, s_ready SHALL be 0, and pushes SHALL be discarded.

Verification
REQ-018 Start-up: reset, enable = 1, push 0x0100, 0x0200, 0x0300 back-to-back.
- PRIME -> RUN after the 2nd push.
- cic_x = 0x0100, 0x0200, 0x0300 on consecutive cycles.
- cic_run rises 3 cycles after RUN entry.
REQ-019 Underrun: in RUN, stop s_valid for 2 cycles.
- cic_x = 0 on those pops.
- underrun pulses twice.
- underrun_cnt = 2.
REQ-020 Saturation: force 300 underruns -> underrun_cnt = 255, no wrap.
REQ-021 Full: s_valid held high with 4 entries and no pop (PRIME_LVL = 4 test) -> s_ready = 0; no entry lost or duplicated.
REQ-022 Drain: enable = 0 with 2 entries queued.
- Both entries emitted in order.
- Then 3 zero cycles.
- Then IDLE and cic_run = 0.
- No underrun pulses.
REQ-023 Mid-operation reset: reset = 0 in RUN with 3 entries queued.
- Next edge: IDLE, FIFO empty, all outputs 0.
- After re-enable, stale samples never appear on cic_x.
